btb_update_sched: RTL and testbench

Sequencer for the branch target buffer's update port. Buffers resolved-branch update requests from the execute stage in a small FIFO and issues them to the BTB one per cycle. Inserts a one-cycle bubble whenever two consecutive issues would target the same BTB index; the BTB commits its set write one cycle after accepting an update, so back-to-back same-index updates would otherwise read a stale set. Sits between the execute/branch-resolve logic and the BTB's `update`/`update_pc`/`update_target`/`mispredicted` inputs.

---
 rtl/btb_update_sched.sv | 163 ++++++++++++++++
 tb/tb_btb_update_sched.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/btb_update_sched.sv
// btb_update_sched: sequences resolved-branch updates into the BTB update port.
//
// Requests from execute are buffered in a DEPTH-entry FIFO. The head entry is
// issued one per cycle, but an issue is held back for one cycle when the head
// targets the same BTB set index as the update currently on the port. The BTB
// commits its set write one cycle after accepting an update, so a
// back-to-back write to the same set would otherwise merge into stale data.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   in_valid/in_ready      request handshake (in_ready = !full)
//   in_pc/in_target        resolved branch PC and target
//   in_mispredicted        resolved mispredict flag
//   hold                   suppresses new issues while high
//   btb_update*            registered update strobe and payload to the BTB
//   count/empty/full       FIFO occupancy
//   stat_*                 saturating 16-bit statistics (BTB_UPD_STATS_EN only)
//
// Optional feature macro: BTB_UPD_STATS_EN adds the statistics counters.
module btb_update_sched #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned INDEX_LSB = 2,
  parameter int unsigned INDEX_W   = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_pc,
  input  logic [31:0]            in_target,
  input  logic                   in_mispredicted,
  input  logic                   hold,
  output logic                   btb_update,
  output logic [31:0]            btb_update_pc,
  output logic [31:0]            btb_update_target,
  output logic                   btb_mispredicted,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
`ifdef BTB_UPD_STATS_EN
  output logic [15:0]            stat_issued,
  output logic [15:0]            stat_mispred,
  output logic [15:0]            stat_bubbles,
`endif
  output logic                   full
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] FullCount = CntW'(DEPTH);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StActive = 2'd1;
  localparam logic [1:0] StBubble = 2'd2;

  logic [31:0]        mem_pc  [DEPTH];
  logic [31:0]        mem_tgt [DEPTH];
  logic               mem_mis [DEPTH];

  logic [PtrW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]    count_q, count_d;
  logic [1:0]         state_q, state_d;

  logic               push, pop, hazard, blocked;
  logic [31:0]        head_pc;
  logic [INDEX_W-1:0] head_idx, last_idx;

  assign count    = count_q;
  assign empty    = (count_q == '0);
  assign full     = (count_q == FullCount);
  assign in_ready = !full;

  assign push     = in_valid && in_ready;
  assign head_pc  = mem_pc[rd_ptr_q];
  assign head_idx = head_pc[INDEX_LSB +: INDEX_W];
  assign last_idx = btb_update_pc[INDEX_LSB +: INDEX_W];

  // Only the update on the port this cycle can collide; once the strobe drops
  // (bubble or hold) the hazard clears by itself.
  assign hazard  = btb_update && (head_idx == last_idx);
  assign pop     = !empty && !hold && !hazard;
  assign blocked = !empty && !hold && hazard;

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!push && pop) begin
      count_d = count_q - 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (push) state_d = StActive;
      end
      StActive: begin
        if (blocked) begin
          state_d = StBubble;
        end else if (count_d == '0) begin
          state_d = StIdle;
        end
      end
      StBubble: state_d = StActive;
      default:  state_d = StIdle;
    endcase
  end

  // Storage carries no reset; occupancy and pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[wr_ptr_q]  <= in_pc;
      mem_tgt[wr_ptr_q] <= in_target;
      mem_mis[wr_ptr_q] <= in_mispredicted;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q          <= '0;
      rd_ptr_q          <= '0;
      count_q           <= '0;
      state_q           <= StIdle;
      btb_update        <= 1'b0;
      btb_update_pc     <= '0;
      btb_update_target <= '0;
      btb_mispredicted  <= 1'b0;
    end else begin
      count_q <= count_d;
      state_q <= state_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      btb_update <= pop;
      if (pop) begin
        rd_ptr_q          <= rd_ptr_q + 1'b1;
        btb_update_pc     <= head_pc;
        btb_update_target <= mem_tgt[rd_ptr_q];
        btb_mispredicted  <= mem_mis[rd_ptr_q];
      end
    end
  end

`ifdef BTB_UPD_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_issued  <= '0;
      stat_mispred <= '0;
      stat_bubbles <= '0;
    end else begin
      if (btb_update && (stat_issued != 16'hFFFF)) begin
        stat_issued <= stat_issued + 16'd1;
      end
      if (btb_update && btb_mispredicted && (stat_mispred != 16'hFFFF)) begin
        stat_mispred <= stat_mispred + 16'd1;
      end
      if ((state_q == StBubble) && (stat_bubbles != 16'hFFFF)) begin
        stat_bubbles <= stat_bubbles + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_btb_update_sched.sv
// Testbench for btb_update_sched: a directed per-cycle vector table, hand
// sequences for full-FIFO and mid-burst reset, then random traffic checked
// against a queue-based reference model. With BTB_UPD_STATS_EN it also checks
// the statistics counters and streams 70000 updates to reach saturation.
module tb_btb_update_sched;

  localparam int unsigned DEPTH     = 4;
  localparam int unsigned INDEX_LSB = 2;
  localparam int unsigned INDEX_W   = 3;

  logic        clk, rst, in_valid, in_ready, in_mispredicted, hold;
  logic [31:0] in_pc, in_target;
  logic        btb_update, btb_mispredicted;
  logic [31:0] btb_update_pc, btb_update_target;
  logic [2:0]  count;
  logic        empty, full;
`ifdef BTB_UPD_STATS_EN
  logic [15:0] stat_issued, stat_mispred, stat_bubbles;
`endif

  btb_update_sched #(
    .DEPTH     (DEPTH),
    .INDEX_LSB (INDEX_LSB),
    .INDEX_W   (INDEX_W)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_pc             (in_pc),
    .in_target         (in_target),
    .in_mispredicted   (in_mispredicted),
    .hold              (hold),
    .btb_update        (btb_update),
    .btb_update_pc     (btb_update_pc),
    .btb_update_target (btb_update_target),
    .btb_mispredicted  (btb_mispredicted),
    .count             (count),
    .empty             (empty),
`ifdef BTB_UPD_STATS_EN
    .stat_issued       (stat_issued),
    .stat_mispred      (stat_mispred),
    .stat_bubbles      (stat_bubbles),
`endif
    .full              (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic [31:0] tgt;
    logic        mis;
    logic        e_upd;
    logic [31:0] e_pc;
    logic [31:0] e_tgt;
    logic        e_mis;
    int          e_cnt;
  } vec_t;

  function automatic vec_t mk(logic v, logic [31:0] pc, logic [31:0] tgt, logic mis,
                              logic e_upd, logic [31:0] e_pc, logic [31:0] e_tgt,
                              logic e_mis, int e_cnt);
    vec_t r;
    r.v = v; r.pc = pc; r.tgt = tgt; r.mis = mis;
    r.e_upd = e_upd; r.e_pc = e_pc; r.e_tgt = e_tgt; r.e_mis = e_mis; r.e_cnt = e_cnt;
    return r;
  endfunction

  vec_t tbl [16];

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] tgt;
    logic        mis;
  } ent_t;

  ent_t        mq[$];
  logic        m_upd;
  ent_t        m_out;
  logic        m_bub;
  int unsigned m_iss, m_mp, m_bb;

  function automatic int unsigned idx_of(logic [31:0] pc);
    return (pc >> INDEX_LSB) & ((32'd1 << INDEX_W) - 1);
  endfunction

  task automatic model_clear();
    mq.delete();
    m_upd = 1'b0;
    m_out = '0;
    m_bub = 1'b0;
    m_iss = 0;
    m_mp  = 0;
    m_bb  = 0;
  endtask

  task automatic mstep(input logic v, input logic [31:0] pc, input logic [31:0] tgt,
                       input logic mis, input logic h, input logic r);
    ent_t e;
    logic rdy, psh, hz, iss;
    in_valid = v; in_pc = pc; in_target = tgt; in_mispredicted = mis; hold = h; rst = r;
    rdy = (mq.size() < DEPTH);
    chk("m_upd", btb_update, m_upd);
    chk("m_pc", btb_update_pc, m_out.pc);
    chk("m_tgt", btb_update_target, m_out.tgt);
    chk("m_mis", btb_mispredicted, m_out.mis);
    chk("m_count", count, mq.size());
    chk("m_ready", in_ready, rdy);
    chk("m_empty", empty, mq.size() == 0);
    chk("m_full", full, mq.size() == DEPTH);
`ifdef BTB_UPD_STATS_EN
    chk("m_stat_issued", stat_issued, m_iss);
    chk("m_stat_mispred", stat_mispred, m_mp);
    chk("m_stat_bubbles", stat_bubbles, m_bb);
`endif
    if (r) begin
      model_clear();
    end else begin
      if (m_upd && m_iss < 65535) m_iss++;
      if (m_upd && m_out.mis && m_mp < 65535) m_mp++;
      if (m_bub && m_bb < 65535) m_bb++;
      psh = v && rdy;
      hz  = m_upd && (mq.size() > 0) && (idx_of(mq[0].pc) == idx_of(m_out.pc));
      iss = (mq.size() > 0) && !h && !hz;
      m_bub = (mq.size() > 0) && !h && hz;
      if (iss) begin
        m_out = mq.pop_front();
        m_upd = 1'b1;
      end else begin
        m_upd = 1'b0;
      end
      if (psh) begin
        e.pc = pc; e.tgt = tgt; e.mis = mis;
        mq.push_back(e);
      end
    end
    step();
  endtask

  logic [31:0] got[$];
  logic [31:0] exp_pcs [5];
  int          first_c, last_c, acc_c, n_acc;
  logic        acc;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_pc = '0; in_target = '0;
    in_mispredicted = 1'b0; hold = 1'b0;

    tbl[0]  = mk(1, 32'h100, 32'h200, 1, 0, 32'h0,   32'h0,   0, 0);
    tbl[1]  = mk(0, 32'h0,   32'h0,   0, 0, 32'h0,   32'h0,   0, 1);
    tbl[2]  = mk(0, 32'h0,   32'h0,   0, 1, 32'h100, 32'h200, 1, 0);
    tbl[3]  = mk(0, 32'h0,   32'h0,   0, 0, 32'h100, 32'h200, 1, 0);
    tbl[4]  = mk(1, 32'h104, 32'h204, 0, 0, 32'h100, 32'h200, 1, 0);
    tbl[5]  = mk(1, 32'h108, 32'h208, 0, 0, 32'h100, 32'h200, 1, 1);
    tbl[6]  = mk(1, 32'h10C, 32'h20C, 0, 1, 32'h104, 32'h204, 0, 1);
    tbl[7]  = mk(0, 32'h0,   32'h0,   0, 1, 32'h108, 32'h208, 0, 1);
    tbl[8]  = mk(0, 32'h0,   32'h0,   0, 1, 32'h10C, 32'h20C, 0, 0);
    tbl[9]  = mk(0, 32'h0,   32'h0,   0, 0, 32'h10C, 32'h20C, 0, 0);
    tbl[10] = mk(1, 32'h100, 32'h300, 1, 0, 32'h10C, 32'h20C, 0, 0);
    tbl[11] = mk(1, 32'h120, 32'h320, 0, 0, 32'h10C, 32'h20C, 0, 1);
    tbl[12] = mk(0, 32'h0,   32'h0,   0, 1, 32'h100, 32'h300, 1, 1);
    tbl[13] = mk(0, 32'h0,   32'h0,   0, 0, 32'h100, 32'h300, 1, 1);
    tbl[14] = mk(0, 32'h0,   32'h0,   0, 1, 32'h120, 32'h320, 0, 0);
    tbl[15] = mk(0, 32'h0,   32'h0,   0, 0, 32'h120, 32'h320, 0, 0);

    step();
    step();
    rst = 1'b0;
    chk("rst_upd", btb_update, 0);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_pc", btb_update_pc, 0);

    // Single request, distinct indices, same index.
    for (int i = 0; i < 16; i++) begin
      in_valid = tbl[i].v; in_pc = tbl[i].pc; in_target = tbl[i].tgt;
      in_mispredicted = tbl[i].mis;
      chk($sformatf("tbl%0d_upd", i), btb_update, tbl[i].e_upd);
      chk($sformatf("tbl%0d_pc", i), btb_update_pc, tbl[i].e_pc);
      chk($sformatf("tbl%0d_tgt", i), btb_update_target, tbl[i].e_tgt);
      chk($sformatf("tbl%0d_mis", i), btb_mispredicted, tbl[i].e_mis);
      chk($sformatf("tbl%0d_count", i), count, tbl[i].e_cnt);
      step();
    end
`ifdef BTB_UPD_STATS_EN
    chk("tbl_stat_issued", stat_issued, 6);
    chk("tbl_stat_mispred", stat_mispred, 2);
    chk("tbl_stat_bubbles", stat_bubbles, 1);
`endif

    // Full FIFO under hold, fifth request stalls until a pop frees a slot.
    hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_pc = 32'h200 + 32'(4 * i); in_target = 32'h400 + 32'(4 * i);
      in_mispredicted = i[0];
      chk($sformatf("fill%0d_ready", i), in_ready, 1);
      step();
    end
    in_pc = 32'h210; in_target = 32'h410; in_mispredicted = 1'b0;
    chk("full_full", full, 1);
    chk("full_ready", in_ready, 0);
    chk("full_count", count, 4);
    for (int i = 0; i < 2; i++) begin
      step();
      chk($sformatf("held%0d_count", i), count, 4);
      chk($sformatf("held%0d_upd", i), btb_update, 0);
    end
    hold = 1'b0;
    got.delete(); first_c = -1; last_c = -1; acc_c = -1; n_acc = 0;
    for (int c = 0; c < 20; c++) begin
      if (btb_update) begin
        got.push_back(btb_update_pc);
        if (first_c < 0) first_c = c;
        last_c = c;
      end
      acc = in_valid && in_ready;
      if (acc) begin
        n_acc++;
        acc_c = c;
      end
      step();
      if (acc) in_valid = 1'b0;
    end
    exp_pcs[0] = 32'h200; exp_pcs[1] = 32'h204; exp_pcs[2] = 32'h208;
    exp_pcs[3] = 32'h20C; exp_pcs[4] = 32'h210;
    chk("drain_n_strobes", got.size(), 5);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("drain%0d_pc", i), (i < got.size()) ? got[i] : 32'hDEAD, exp_pcs[i]);
    end
    chk("drain_span", last_c - first_c, 4);
    chk("drain_first", first_c, 1);
    chk("fifth_accepts", n_acc, 1);
    chk("fifth_accept_cycle", acc_c, 1);

    // Reset for two cycles with three entries queued and one in flight.
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_pc = 32'h300 + 32'(4 * i); in_target = 32'h500; in_mispredicted = 1;
      step();
    end
    in_valid = 1'b0; hold = 1'b0;
    step();
    chk("pre_rst_upd", btb_update, 1);
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk($sformatf("midrst%0d_count", i), count, 0);
      chk($sformatf("midrst%0d_upd", i), btb_update, 0);
      chk($sformatf("midrst%0d_ready", i), in_ready, 1);
      chk($sformatf("midrst%0d_empty", i), empty, 1);
      chk($sformatf("midrst%0d_pc", i), btb_update_pc, 0);
      chk($sformatf("midrst%0d_tgt", i), btb_update_target, 0);
      chk($sformatf("midrst%0d_mis", i), btb_mispredicted, 0);
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("postrst%0d_upd", i), btb_update, 0);
      chk($sformatf("postrst%0d_count", i), count, 0);
      step();
    end
`ifdef BTB_UPD_STATS_EN
    chk("postrst_stat_issued", stat_issued, 0);
    chk("postrst_stat_bubbles", stat_bubbles, 0);
`endif

    // Random traffic against the reference model; DUT is freshly reset.
    model_clear();
    for (int i = 0; i < 3000; i++) begin
      mstep(($urandom_range(0, 99) < 60),
            ($urandom & 32'hFFFF_FF00) | (32'($urandom_range(0, 3)) << 2),
            $urandom, 1'($urandom), ($urandom_range(0, 99) < 20),
            ($urandom_range(0, 299) == 0));
    end

`ifdef BTB_UPD_STATS_EN
    // Stream distinct consecutive indices long enough to saturate stat_issued.
    mstep(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 70000; i++) begin
      mstep(1, 32'(i) << 2, ~(32'(i) << 2), (i % 3 == 0), 0, 0);
    end
    for (int i = 0; i < 8; i++) mstep(0, 0, 0, 0, 0, 0);
    chk("sat_stat_issued", stat_issued, 32'hFFFF);
    chk("sat_drained", count, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
